spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter that shares one SPI master byte engine (start / tx_data / busy / done / rx_data handshake) between N_REQ on-chip requesters. It accepts one byte request per grant, launches the master, returns the received byte to the owner, and guards each transfer with a done-timeout. Optional per-requester lock holds ownership across consecutive bytes so a multi-byte frame is not interleaved. Sits between the requester clients and the SPI master, in the master's clock domain.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT, 1024, cycles to wait for done before aborting (≥ 16)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester byte request, level
- lock  input  N_REQ  per-requester: keep ownership after this byte
- req_data  input  8*N_REQ  byte to send, requester k at bits [8k+7:8k]
- gnt  output  N_REQ  one-hot, one-cycle pulse: request accepted
- rsp_valid  output  N_REQ  one-hot, one-cycle pulse: transfer finished
- rsp_data  output  8  received byte, valid with rsp_valid
- rsp_err  output  1  timeout flag, valid with rsp_valid
- start  output  1  to master, one-cycle launch pulse
- tx_data  output  8  to master, byte to send, held stable while in WAIT
- busy  input  1  from master, transfer in progress
- done  input  1  from master, one-cycle completion pulse
- rx_data  input  8  from master, received byte, valid with done

## Operation
- States: IDLE, WAIT. All outputs registered; reset: state IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, start=0, tx_data=0, ptr=0, owner=0, locked=0, timer=0.
- IDLE: arbitrate only when |req and busy==0. Winner: if locked and req[owner], owner; else first set req bit searching from ptr upward, wrapping at N_REQ-1 → 0.
- On win k: gnt[k]=1, start=1, tx_data=req_data[k], owner=k, locked=lock[k], timer=0, → WAIT.
- ptr update at grant: ptr = locked_new ? k : (k+1) mod N_REQ.
- WAIT: timer increments each cycle. On done: rsp_data=rx_data, rsp_err=0, rsp_valid[owner]=1, → IDLE. On timer==TIMEOUT-1 without done: rsp_data=0, rsp_err=1, rsp_valid[owner]=1, locked=0, → IDLE.
- done and timeout in the same cycle: done wins, rsp_err=0.
- done or busy while IDLE with no grant: ignored.
- Lock release: requester deasserts lock on its final byte; also released if owner's req is low when IDLE arbitrates (normal round-robin resumes from ptr).
- Requester contract: hold req and req_data stable until gnt; drop or re-present next byte the cycle after gnt. Dropping req before gnt is legal, no effect.
- Reset mid-transfer: all outputs return to reset values immediately; no rsp_valid for the aborted byte.

## Timing
- req seen at edge T (IDLE, busy=0) → gnt and start high during cycle T+1, exactly one cycle each.
- done high at edge D → rsp_valid/rsp_data/rsp_err during cycle D+1; state IDLE at D+1.
- Earliest next grant: cycle D+2 (back-to-back throughput: one idle cycle between bytes).
- Timeout: rsp_valid with rsp_err=1 in cycle T+1+TIMEOUT after grant.
- timer width: $clog2(TIMEOUT)+1, no wrap possible.

## Structure
- Package spi_arb_pkg: state enum (IDLE, WAIT), BYTE_W=8, default N_REQ and TIMEOUT constants.
- Sub-module spi_rr_pick: combinational round-robin picker (req, ptr → one-hot winner, any). Arbiter top owns FSM, timer, lock and registered outputs.

## Test plan
- Single request: req=0010, req_data[1]=8'hA5, master returns 8'h3C → gnt=0010 and start one cycle, tx_data=A5, rsp_valid=0010, rsp_data=3C, rsp_err=0.
- Fairness: req=1111 held, no lock, 8 transfers → grant order 0,1,2,3,0,1,2,3.
- Lock: req=0011, lock[1]=1 for 3 bytes then 0 → requester 1 gets 3 consecutive grants after first win, then requester 0.
- Timeout: grant requester 2, done never asserted → rsp_valid=0100, rsp_err=1, rsp_data=0 exactly TIMEOUT cycles after start; next request served normally.
- Busy gate and collisions: busy=1 with req pending → no grant until busy=0; done on timeout cycle → rsp_err=0.
- Reset in WAIT: rst_n low mid-transfer → all outputs 0 immediately, ptr=0; after release req=1000 granted normally.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// spi_arb_pkg: shared state type, byte width and default sizing for the SPI arbiter
package spi_arb_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_TIMEOUT = 1024;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic int next_idx(input int k, input int n);
    return (k + 1 == n) ? 0 : k + 1;
  endfunction
endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester-side and SPI-master-side handshake bundle
interface spi_arbiter_if
  import spi_arb_pkg::*;
#(parameter int N_REQ = DEF_N_REQ);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] lock;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rsp_valid;
  logic [BYTE_W-1:0] rsp_data;
  logic rsp_err;
  logic start;
  logic [BYTE_W-1:0] tx_data;
  logic busy;
  logic done;
  logic [BYTE_W-1:0] rx_data;
  modport slave (
    input req, lock, req_data, busy, done, rx_data,
    output gnt, rsp_valid, rsp_data, rsp_err, start, tx_data
  );
  modport master (
    output req, lock, req_data, busy, done, rx_data,
    input gnt, rsp_valid, rsp_data, rsp_err, start, tx_data
  );
endinterface

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: first set request at or above ptr, wrapping, as one-hot and index
module spi_rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW-1:0] j;
  // scan from farthest offset down so the nearest set bit to ptr is kept last
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI byte engine with lock and done-timeout
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  spi_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, owner, owner_n, win, pick_idx;
  logic locked, locked_n, hold, pick_any;
  logic [TW-1:0] timer, timer_n;
  logic [N_REQ-1:0] pick_oh, gnt_n, rv_n;
  logic start_n, err_n;
  logic [BYTE_W-1:0] tx_n, rd_n;

  spi_rr_pick #(.N(N_REQ)) u_pick (
    .req(bus.req),
    .ptr(ptr),
    .gnt(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );

  // a locked owner that is still requesting keeps the engine
  assign hold = locked && bus.req[owner];
  assign win = hold ? owner : pick_idx;

  // next state, bookkeeping and next registered outputs
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    locked_n = locked;
    timer_n = timer;
    gnt_n = '0;
    rv_n = '0;
    start_n = 1'b0;
    tx_n = bus.tx_data;
    rd_n = bus.rsp_data;
    err_n = bus.rsp_err;
    if (state == IDLE) begin
      if (pick_any && !bus.busy) begin
        state_n = WAIT;
        gnt_n = hold ? N_REQ'(1) << owner : pick_oh;
        start_n = 1'b1;
        tx_n = bus.req_data[win*BYTE_W +: BYTE_W];
        owner_n = win;
        locked_n = bus.lock[win];
        ptr_n = bus.lock[win] ? win : PW'(next_idx(int'(win), N_REQ));
        timer_n = '0;
      end
    end else begin
      timer_n = timer + 1'b1;
      if (bus.done) begin
        state_n = IDLE;
        rv_n = N_REQ'(1) << owner;
        rd_n = bus.rx_data;
        err_n = 1'b0;
      end else if (timer == TW'(TIMEOUT - 1)) begin
        state_n = IDLE;
        rv_n = N_REQ'(1) << owner;
        rd_n = '0;
        err_n = 1'b1;
        locked_n = 1'b0;
      end
    end
  end

  // state register and registered outputs, all cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      locked <= 1'b0;
      timer <= '0;
      bus.gnt <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
      bus.start <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      locked <= locked_n;
      timer <= timer_n;
      bus.gnt <= gnt_n;
      bus.rsp_valid <= rv_n;
      bus.rsp_data <= rd_n;
      bus.rsp_err <= err_n;
      bus.start <= start_n;
      bus.tx_data <= tx_n;
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed table, corner sequences and randomized model check
module tb_spi_arbiter;
  import spi_arb_pkg::*;
  localparam int N = 4;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_arbiter_if #(.N_REQ(N)) bus();
  spi_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vecs = 0;
  int errs = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [31:0] data;
    logic [7:0] rx;
    int lat;
    bit nodone;
    logic [3:0] egnt;
    logic [7:0] etx;
    logic [7:0] erd;
    bit eerr;
  } vec_t;
  vec_t tbl[18];
  logic [3:0] p_req, p_lock, n_req, n_lock, e_gnt, e_rv;
  logic [31:0] p_data, n_data;
  logic p_busy, p_done, n_busy, n_done, e_start, m_re;
  logic [7:0] p_rx, n_rx, m_tx, m_rd;
  int m_ptr, m_owner, m_age, mcnt, r, k;
  bit m_wait, m_locked, mact, mnod;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.req = '0;
    bus.lock = '0;
    bus.req_data = '0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.rx_data = '0;
  endtask

  task automatic chk_reset(input string name);
    chk({name, " gnt"}, 32'(bus.gnt), 0);
    chk({name, " rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({name, " rsp_data"}, 32'(bus.rsp_data), 0);
    chk({name, " rsp_err"}, 32'(bus.rsp_err), 0);
    chk({name, " start"}, 32'(bus.start), 0);
    chk({name, " tx_data"}, 32'(bus.tx_data), 0);
  endtask

  task automatic wait_gnt();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.gnt == '0 && n < 20);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int n;
    bus.req = v.req;
    bus.lock = v.lock;
    bus.req_data = v.data;
    wait_gnt();
    chk($sformatf("v%0d gnt", i), 32'(bus.gnt), 32'(v.egnt));
    chk($sformatf("v%0d start", i), 32'(bus.start), 1);
    chk($sformatf("v%0d tx_data", i), 32'(bus.tx_data), 32'(v.etx));
    bus.req = '0;
    bus.busy = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d pulse", i), {27'd0, bus.start, bus.gnt}, 0);
    if (v.nodone) begin
      n = 1;
      while (bus.rsp_valid == '0 && n < TO + 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d timeout cycles", i), n, TO);
    end else begin
      repeat (v.lat - 1) @(negedge clk);
      bus.done = 1'b1;
      bus.rx_data = v.rx;
      @(negedge clk);
    end
    chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(v.egnt));
    chk($sformatf("v%0d rsp_data", i), 32'(bus.rsp_data), 32'(v.erd));
    chk($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err), 32'(v.eerr));
    bus.done = 1'b0;
    bus.busy = 1'b0;
  endtask

  function automatic int rr(input logic [3:0] rq, input int p);
    int best = -1;
    int bd = N;
    for (int q = 0; q < N; q++)
      if (rq[q] && (q - p + N) % N < bd) begin
        bd = (q - p + N) % N;
        best = q;
      end
    return best;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'hF, 4'h0, 32'h44332211, 8'h81, 1, 0, 4'h1, 8'h11, 8'h81, 0};
    tbl[1]  = '{4'hF, 4'h0, 32'h44332211, 8'h82, 2, 0, 4'h2, 8'h22, 8'h82, 0};
    tbl[2]  = '{4'hF, 4'h0, 32'h44332211, 8'h83, 3, 0, 4'h4, 8'h33, 8'h83, 0};
    tbl[3]  = '{4'hF, 4'h0, 32'h44332211, 8'h84, 1, 0, 4'h8, 8'h44, 8'h84, 0};
    tbl[4]  = '{4'hF, 4'h0, 32'h44332211, 8'h85, 2, 0, 4'h1, 8'h11, 8'h85, 0};
    tbl[5]  = '{4'hF, 4'h0, 32'h44332211, 8'h86, 1, 0, 4'h2, 8'h22, 8'h86, 0};
    tbl[6]  = '{4'hF, 4'h0, 32'h44332211, 8'h87, 4, 0, 4'h4, 8'h33, 8'h87, 0};
    tbl[7]  = '{4'hF, 4'h0, 32'h44332211, 8'h88, 1, 0, 4'h8, 8'h44, 8'h88, 0};
    tbl[8]  = '{4'h2, 4'h0, 32'h0000A500, 8'h3C, 3, 0, 4'h2, 8'hA5, 8'h3C, 0};
    tbl[9]  = '{4'h2, 4'h2, 32'h0000B100, 8'hC1, 2, 0, 4'h2, 8'hB1, 8'hC1, 0};
    tbl[10] = '{4'h3, 4'h2, 32'h0000B2D0, 8'hC2, 1, 0, 4'h2, 8'hB2, 8'hC2, 0};
    tbl[11] = '{4'h3, 4'h2, 32'h0000B3D0, 8'hC3, 2, 0, 4'h2, 8'hB3, 8'hC3, 0};
    tbl[12] = '{4'h3, 4'h0, 32'h0000B4D0, 8'hC4, 1, 0, 4'h2, 8'hB4, 8'hC4, 0};
    tbl[13] = '{4'h3, 4'h0, 32'h0000B5D5, 8'hC5, 2, 0, 4'h1, 8'hD5, 8'hC5, 0};
    tbl[14] = '{4'h2, 4'h2, 32'h0000E600, 8'hC6, 1, 0, 4'h2, 8'hE6, 8'hC6, 0};
    tbl[15] = '{4'h1, 4'h0, 32'h000000E7, 8'hC7, 2, 0, 4'h1, 8'hE7, 8'hC7, 0};
    tbl[16] = '{4'h4, 4'h0, 32'h00770000, 8'h00, 0, 1, 4'h4, 8'h77, 8'h00, 1};
    tbl[17] = '{4'h8, 4'h0, 32'h88000000, 8'h99, 3, 0, 4'h8, 8'h88, 8'h99, 0};
    idle_in();
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) run_vec(tbl[i], i);
    bus.busy = 1'b1;
    bus.req = 4'h1;
    bus.req_data = 32'h000000F1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("busy gate %0d", i), 32'(bus.gnt), 0);
    end
    bus.busy = 1'b0;
    @(negedge clk);
    chk("busy release gnt", 32'(bus.gnt), 1);
    chk("busy release tx", 32'(bus.tx_data), 32'hF1);
    bus.req = '0;
    bus.busy = 1'b1;
    @(negedge clk);
    bus.done = 1'b1;
    bus.rx_data = 8'h1F;
    @(negedge clk);
    chk("busy xfer rsp", {bus.rsp_err, bus.rsp_data, bus.rsp_valid}, {1'b0, 8'h1F, 4'h1});
    idle_in();
    bus.req = 4'h2;
    bus.req_data = 32'h0000F200;
    wait_gnt();
    chk("collide gnt", 32'(bus.gnt), 2);
    bus.req = '0;
    bus.busy = 1'b1;
    repeat (TO - 1) @(negedge clk);
    bus.done = 1'b1;
    bus.rx_data = 8'h5A;
    @(negedge clk);
    chk("collide rsp_valid", 32'(bus.rsp_valid), 2);
    chk("collide rsp_err", 32'(bus.rsp_err), 0);
    chk("collide rsp_data", 32'(bus.rsp_data), 32'h5A);
    idle_in();
    bus.done = 1'b1;
    bus.busy = 1'b1;
    bus.rx_data = 8'hFF;
    @(negedge clk);
    chk("spurious done rsp", 32'(bus.rsp_valid), 0);
    idle_in();
    @(negedge clk);
    chk("spurious idle", {bus.start, bus.gnt, bus.rsp_valid}, 0);
    bus.req = 4'h8;
    bus.req_data = 32'hAB000000;
    wait_gnt();
    chk("prereset gnt", 32'(bus.gnt), 8);
    chk("prereset tx", 32'(bus.tx_data), 32'hAB);
    bus.req = '0;
    bus.busy = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset");
    @(negedge clk);
    chk("reset hold rsp", 32'(bus.rsp_valid), 0);
    idle_in();
    rst_n = 1'b1;
    bus.req = 4'hF;
    bus.req_data = 32'h44332211;
    wait_gnt();
    chk("postreset gnt", 32'(bus.gnt), 1);
    chk("postreset tx", 32'(bus.tx_data), 32'h11);
    bus.req = '0;
    bus.busy = 1'b1;
    @(negedge clk);
    bus.done = 1'b1;
    bus.rx_data = 8'h42;
    @(negedge clk);
    chk("postreset rsp", {bus.rsp_err, bus.rsp_data, bus.rsp_valid}, {1'b0, 8'h42, 4'h1});
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p_req = '0; p_lock = '0; p_data = '0; p_busy = 1'b0; p_done = 1'b0; p_rx = '0;
    m_ptr = 0; m_owner = 0; m_age = 0; m_wait = 0; m_locked = 0;
    m_tx = '0; m_rd = '0; m_re = 1'b0; mact = 0; mnod = 0; mcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      e_gnt = '0;
      e_rv = '0;
      e_start = 1'b0;
      if (!m_wait) begin
        if (p_req != '0 && !p_busy) begin
          k = (m_locked && p_req[m_owner]) ? m_owner : rr(p_req, m_ptr);
          e_gnt = 4'(1 << k);
          e_start = 1'b1;
          m_tx = p_data[8*k +: 8];
          m_owner = k;
          m_locked = p_lock[k];
          m_ptr = p_lock[k] ? k : (k + 1) % N;
          m_wait = 1;
          m_age = 0;
        end
      end else if (p_done) begin
        e_rv = 4'(1 << m_owner);
        m_rd = p_rx;
        m_re = 1'b0;
        m_wait = 0;
      end else if (m_age == TO - 1) begin
        e_rv = 4'(1 << m_owner);
        m_rd = '0;
        m_re = 1'b1;
        m_locked = 0;
        m_wait = 0;
      end else m_age++;
      chk($sformatf("rnd%0d gnt", c), 32'(bus.gnt), 32'(e_gnt));
      chk($sformatf("rnd%0d start", c), 32'(bus.start), 32'(e_start));
      chk($sformatf("rnd%0d tx_data", c), 32'(bus.tx_data), 32'(m_tx));
      chk($sformatf("rnd%0d rsp_valid", c), 32'(bus.rsp_valid), 32'(e_rv));
      chk($sformatf("rnd%0d rsp_data", c), 32'(bus.rsp_data), 32'(m_rd));
      chk($sformatf("rnd%0d rsp_err", c), 32'(bus.rsp_err), 32'(m_re));
      n_done = 1'b0;
      n_busy = 1'b0;
      n_rx = 8'($urandom);
      if (mact) begin
        n_busy = 1'b1;
        if (mnod) begin
          if (bus.rsp_valid != '0) begin
            mact = 0;
            n_busy = 1'b0;
          end
        end else begin
          mcnt--;
          if (mcnt == 0) begin
            n_done = 1'b1;
            mact = 0;
          end
        end
      end else if (bus.start) begin
        mact = 1;
        n_busy = 1'b1;
        r = int'($urandom % 16);
        mnod = (r == 0);
        mcnt = (r == 1) ? TO - 1 : 1 + int'($urandom % 12);
      end else begin
        n_busy = ($urandom % 8 == 0);
        n_done = ($urandom % 16 == 0);
      end
      n_req = p_req;
      n_lock = p_lock;
      n_data = p_data;
      for (int q = 0; q < N; q++) begin
        if (bus.gnt[q]) begin
          if ($urandom % 2 == 1) begin
            n_req[q] = 1'b1;
            n_data[8*q +: 8] = 8'($urandom);
            n_lock[q] = ($urandom % 3 == 0);
          end else begin
            n_req[q] = 1'b0;
            n_lock[q] = 1'b0;
          end
        end else if (!p_req[q]) begin
          if ($urandom % 4 == 0) begin
            n_req[q] = 1'b1;
            n_data[8*q +: 8] = 8'($urandom);
            n_lock[q] = ($urandom % 3 == 0);
          end
        end else if ($urandom % 64 == 0) n_req[q] = 1'b0;
      end
      p_req = n_req; p_lock = n_lock; p_data = n_data;
      p_busy = n_busy; p_done = n_done; p_rx = n_rx;
      bus.req = n_req; bus.lock = n_lock; bus.req_data = n_data;
      bus.busy = n_busy; bus.done = n_done; bus.rx_data = n_rx;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
